// File: rtl/correlation_peak_register.sv
// Scans one frame of SAMPLES*OSF correlation magnitudes, tracks the running maximum
// and its index, and registers peak index/magnitude/detect at frame end.
module correlation_peak_register #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int MAG_W   = 16,
  localparam int IDX_W  = $clog2(SAMPLES*OSF) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             InValid,
  input  logic [MAG_W-1:0] InMag,
  input  logic [MAG_W-1:0] Threshold,
  output logic             Busy,
  output logic             PeakValid,
  output logic [IDX_W-1:0] PeakIdx,
  output logic [MAG_W-1:0] PeakMag,
  output logic             Detected,
  output logic             dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES*OSF - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  // Handshake: a sample is taken on any rising edge where the scan is active,
  // InValid is high and Start is low; there is no backpressure and no timeout.
  state_t           state, state_next;
  logic [IDX_W-1:0] cnt;
  logic [MAG_W-1:0] run_max;
  logic [IDX_W-1:0] run_idx;
  logic             accept;
  logic             last;
  logic             take;
  logic [MAG_W-1:0] new_max;
  logic [IDX_W-1:0] new_idx;

  assign accept    = (state == SCAN) && InValid && !Start;
  assign last      = accept && (cnt == LAST_IDX);
  // Strict compare keeps the earliest index on ties.
  assign take      = (cnt == '0) || (InMag > run_max);
  assign new_max   = take ? InMag : run_max;
  assign new_idx   = take ? cnt : run_idx;
  assign Busy      = (state == SCAN);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = SCAN;
      SCAN:    if (Start) state_next = SCAN;
               else if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      PeakValid <= 1'b0;
      PeakIdx   <= '0;
      PeakMag   <= '0;
      Detected  <= 1'b0;
    end else begin
      state     <= state_next;
      PeakValid <= 1'b0;
      if (Start) begin
        // Start (re)opens a scan; results from earlier frames stay held.
        cnt     <= '0;
        run_max <= '0;
        run_idx <= '0;
      end else if (accept) begin
        if (last) begin
          PeakIdx   <= new_idx;
          PeakMag   <= new_max;
          Detected  <= (new_max >= Threshold);
          PeakValid <= 1'b1;
          cnt       <= '0;
          run_max   <= '0;
          run_idx   <= '0;
        end else begin
          cnt     <= cnt + 1'b1;
          run_max <= new_max;
          run_idx <= new_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_correlation_peak_register.sv
// Directed bench for correlation_peak_register with N=8 (SAMPLES=4, OSF=2), MAG_W=16.
module tb_correlation_peak_register;

  localparam int MAG_W = 16;
  localparam int IDX_W = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic             InValid = 1'b0;
  logic [MAG_W-1:0] InMag = '0;
  logic [MAG_W-1:0] Threshold = '0;
  logic             Busy;
  logic             PeakValid;
  logic [IDX_W-1:0] PeakIdx;
  logic [MAG_W-1:0] PeakMag;
  logic             Detected;
  logic             dbg_state;

  int compared = 0;
  int mismatched = 0;

  logic [MAG_W-1:0] tie_data [8] = '{16'd3, 16'd9, 16'd2, 16'd40, 16'd7, 16'd40, 16'd1, 16'd0};
  logic [MAG_W-1:0] abort_data [5] = '{16'd1, 16'd2, 16'd100, 16'd3, 16'd4};
  logic [MAG_W-1:0] rst_data [8] = '{16'd10, 16'd20, 16'd30, 16'd5, 16'd6, 16'd7, 16'd50, 16'd8};

  correlation_peak_register #(.SAMPLES(4), .OSF(2), .MAG_W(MAG_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InMag(InMag),
    .Threshold(Threshold), .Busy(Busy), .PeakValid(PeakValid), .PeakIdx(PeakIdx),
    .PeakMag(PeakMag), .Detected(Detected), .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle's inputs, let the edge happen, then settle 1ns past it.
  task automatic cycle(input logic s, input logic v, input logic [MAG_W-1:0] m);
    Start = s;
    InValid = v;
    InMag = m;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      Start = 1'($urandom_range(0, 1));
      InValid = 1'($urandom_range(0, 1));
      InMag = 16'($urandom_range(0, 65535));
      Threshold = 16'($urandom_range(0, 65535));
      @(posedge Clk);
      #1;
    end
    compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    compared++; if (PeakValid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b exp=0", PeakValid); end
    compared++; if (PeakIdx !== 4'd0) begin mismatched++; $display("FAIL reset_idx got=%0d exp=0", PeakIdx); end
    compared++; if (PeakMag !== 16'd0) begin mismatched++; $display("FAIL reset_mag got=%0d exp=0", PeakMag); end
    compared++; if (Detected !== 1'b0) begin mismatched++; $display("FAIL reset_det got=%b exp=0", Detected); end
    Reset = 1'b0;
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_ties();
    Threshold = 16'd30;
    cycle(1'b1, 1'b1, 16'd500);
    compared++; if (Busy !== 1'b1) begin mismatched++; $display("FAIL ties_busy_start got=%b exp=1", Busy); end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        compared++; if (PeakValid !== 1'b0) begin mismatched++; $display("FAIL ties_early_valid got=%b exp=0", PeakValid); end
      end
      cycle(1'b0, 1'b1, tie_data[i]);
    end
    compared++; if (PeakValid !== 1'b1) begin mismatched++; $display("FAIL ties_valid got=%b exp=1", PeakValid); end
    compared++; if (PeakIdx !== 4'd3) begin mismatched++; $display("FAIL ties_idx got=%0d exp=3", PeakIdx); end
    compared++; if (PeakMag !== 16'd40) begin mismatched++; $display("FAIL ties_mag got=%0d exp=40", PeakMag); end
    compared++; if (Detected !== 1'b1) begin mismatched++; $display("FAIL ties_det got=%b exp=1", Detected); end
    compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL ties_busy got=%b exp=0", Busy); end
  endtask

  // Starts inside the PeakValid cycle of the previous frame.
  task automatic test_gapped();
    int busy_cycles;
    busy_cycles = 0;
    cycle(1'b1, 1'b0, '0);
    compared++; if (PeakValid !== 1'b0) begin mismatched++; $display("FAIL pulse_width got=%b exp=0", PeakValid); end
    compared++; if (Busy !== 1'b1) begin mismatched++; $display("FAIL b2b_start_busy got=%b exp=1", Busy); end
    if (Busy === 1'b1) busy_cycles++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, tie_data[i]);
      if (Busy === 1'b1) busy_cycles++;
      if (i < 7) begin
        compared++; if (PeakValid !== 1'b0) begin mismatched++; $display("FAIL gap_early_valid i=%0d got=%b exp=0", i, PeakValid); end
        cycle(1'b0, 1'b0, 16'd1000);
        if (Busy === 1'b1) busy_cycles++;
      end
    end
    compared++; if (busy_cycles !== 15) begin mismatched++; $display("FAIL gap_busy_cycles got=%0d exp=15", busy_cycles); end
    compared++; if (PeakValid !== 1'b1) begin mismatched++; $display("FAIL gap_valid got=%b exp=1", PeakValid); end
    compared++; if (PeakIdx !== 4'd3) begin mismatched++; $display("FAIL gap_idx got=%0d exp=3", PeakIdx); end
    compared++; if (PeakMag !== 16'd40) begin mismatched++; $display("FAIL gap_mag got=%0d exp=40", PeakMag); end
    compared++; if (Detected !== 1'b1) begin mismatched++; $display("FAIL gap_det got=%b exp=1", Detected); end
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_threshold();
    Threshold = 16'd6;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'd5);
    compared++; if (PeakValid !== 1'b1) begin mismatched++; $display("FAIL below_valid got=%b exp=1", PeakValid); end
    compared++; if (PeakIdx !== 4'd0) begin mismatched++; $display("FAIL below_idx got=%0d exp=0", PeakIdx); end
    compared++; if (PeakMag !== 16'd5) begin mismatched++; $display("FAIL below_mag got=%0d exp=5", PeakMag); end
    compared++; if (Detected !== 1'b0) begin mismatched++; $display("FAIL below_det got=%b exp=0", Detected); end
    // Equal to threshold counts as detected.
    Threshold = 16'd5;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'd5);
    compared++; if (Detected !== 1'b1) begin mismatched++; $display("FAIL equal_det got=%b exp=1", Detected); end
    Threshold = 16'd6;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, (i == 7) ? 16'd65535 : 16'd0);
    compared++; if (PeakIdx !== 4'd7) begin mismatched++; $display("FAIL last_idx got=%0d exp=7", PeakIdx); end
    compared++; if (PeakMag !== 16'd65535) begin mismatched++; $display("FAIL last_mag got=%0d exp=65535", PeakMag); end
    compared++; if (Detected !== 1'b1) begin mismatched++; $display("FAIL last_det got=%b exp=1", Detected); end
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_restart();
    int pulses;
    pulses = 0;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, abort_data[i]);
      if (PeakValid === 1'b1) pulses++;
    end
    cycle(1'b1, 1'b1, 16'd999);
    if (PeakValid === 1'b1) pulses++;
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (PeakIdx !== 4'd7 || PeakMag !== 16'd65535 || Detected !== 1'b1) begin
        mismatched++; $display("FAIL restart_hold i=%0d got=%0d/%0d/%b exp=7/65535/1", i, PeakIdx, PeakMag, Detected);
      end
      cycle(1'b0, 1'b1, rst_data[i]);
      if (PeakValid === 1'b1) pulses++;
    end
    cycle(1'b0, 1'b0, '0);
    if (PeakValid === 1'b1) pulses++;
    compared++; if (pulses !== 1) begin mismatched++; $display("FAIL restart_pulses got=%0d exp=1", pulses); end
    compared++; if (PeakIdx !== 4'd6) begin mismatched++; $display("FAIL restart_idx got=%0d exp=6", PeakIdx); end
    compared++; if (PeakMag !== 16'd50) begin mismatched++; $display("FAIL restart_mag got=%0d exp=50", PeakMag); end
    // Start landing on what would have been the frame-completing sample.
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 16'd9);
    cycle(1'b1, 1'b1, 16'd9);
    compared++; if (PeakValid !== 1'b0) begin mismatched++; $display("FAIL restart_last_valid got=%b exp=0", PeakValid); end
    compared++; if (Busy !== 1'b1) begin mismatched++; $display("FAIL restart_last_busy got=%b exp=1", Busy); end
    compared++; if (PeakMag !== 16'd50) begin mismatched++; $display("FAIL restart_last_mag got=%0d exp=50", PeakMag); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'd77);
    Reset = 1'b1;
    cycle(1'b0, 1'b1, 16'd77);
    Reset = 1'b0;
    compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy got=%b exp=0", Busy); end
    compared++;
    if (PeakValid !== 1'b0 || PeakIdx !== 4'd0 || PeakMag !== 16'd0 || Detected !== 1'b0) begin
      mismatched++; $display("FAIL mid_outputs got=%b/%0d/%0d/%b exp=0/0/0/0", PeakValid, PeakIdx, PeakMag, Detected);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 16'd200);
      if (PeakValid === 1'b1 || Busy === 1'b1) pulses++;
    end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL mid_no_start_activity got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_ties();
    test_gapped();
    test_threshold();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
